// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage and its consumers.
//   XLEN        data/address width
//   NOP_INSTR   canonical bubble (addi x0,x0,0) placed in IF/ID on reset/flush
//   OP_*        major opcodes (instr[6:0]) decoded downstream
//   fetch_state_e  fetch controller states
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched (pc, instr) pair that arrived while
// decode was stalled.
//   clk, rst          clock / synchronous active-high reset
//   load              capture load_pc/load_instr, mark valid
//   clear             empty the buffer (wins over load)
//   load_pc/instr     data to capture
//   valid, pc, instr  buffer contents
module if_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  logic            valid_reg;
  logic [XLEN-1:0] pc_reg;
  logic [31:0]     instr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage. Owns the PC, issues one outstanding request at a time
// to instruction memory and drives the IF/ID register consumed by decode.
//   clk, rst                   clock / synchronous active-high reset
//   imem_req, imem_addr        request held with stable address until imem_ack
//   imem_ack, imem_rdata       1-cycle completion with data
//   stall                      decode cannot accept; IF/ID holds
//   redirect, redirect_pc      taken branch/jump: flush and refetch
//   id_valid, id_pc, id_instr  IF/ID register
module instr_fetch #(
  parameter int               XLEN      = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr
);

  import rv_pkg::*;

  fetch_state_e    state_reg, state_next;
  // pc_reg is the next address to request; in DROP it holds the redirect target
  // while imem_addr stays on the abandoned request.
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic            req_reg, req_next;
  logic            id_valid_reg, id_valid_next;
  logic [XLEN-1:0] id_pc_reg, id_pc_next;
  logic [31:0]     id_instr_reg, id_instr_next;

  logic            skid_load, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect_lsb_unused;

  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_plus4            = pc_reg + XLEN'(4);
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  if_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_pc    (pc_reg),
    .load_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      addr_reg     <= RESET_PC;
      req_reg      <= 1'b0;
      id_valid_reg <= 1'b0;
      id_pc_reg    <= RESET_PC;
      id_instr_reg <= NOP_INSTR;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      addr_reg     <= addr_next;
      req_reg      <= req_next;
      id_valid_reg <= id_valid_next;
      id_pc_reg    <= id_pc_next;
      id_instr_reg <= id_instr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    addr_next     = addr_reg;
    req_next      = req_reg;
    id_valid_next = id_valid_reg;
    id_pc_next    = id_pc_reg;
    id_instr_next = id_instr_reg;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;

    if (redirect) begin
      // Flush beats stall and any ack arriving this cycle.
      id_valid_next = 1'b0;
      id_instr_next = NOP_INSTR;
      skid_clear    = 1'b1;
      pc_next       = redirect_target;
      req_next      = 1'b1;
      if ((state_reg == REQ || state_reg == DROP) && !imem_ack) begin
        // Memory still owes us a word for the old address; keep asking for it
        // so the handshake completes, then discard it.
        state_next = DROP;
      end else begin
        state_next = REQ;
        addr_next  = redirect_target;
      end
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next = REQ;
          req_next   = 1'b1;
          addr_next  = pc_reg;
        end
        REQ: begin
          if (imem_ack) begin
            pc_next   = pc_plus4;
            addr_next = pc_plus4;
            if (!id_valid_reg || !stall) begin
              id_valid_next = 1'b1;
              id_pc_next    = pc_reg;
              id_instr_next = imem_rdata;
            end else begin
              skid_load  = 1'b1;
              req_next   = 1'b0;
              state_next = FULL;
            end
          end else if (id_valid_reg && !stall) begin
            id_valid_next = 1'b0;
          end
        end
        FULL: begin
          if (!stall && skid_valid) begin
            id_valid_next = 1'b1;
            id_pc_next    = skid_pc;
            id_instr_next = skid_instr;
            skid_clear    = 1'b1;
            state_next    = REQ;
            req_next      = 1'b1;
            addr_next     = pc_reg;
          end
        end
        DROP: begin
          if (id_valid_reg && !stall) begin
            id_valid_next = 1'b0;
          end
          if (imem_ack) begin
            state_next = REQ;
            addr_next  = pc_reg;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign id_valid  = id_valid_reg;
  assign id_pc     = id_pc_reg;
  assign id_instr  = id_instr_reg;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ack_en;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  // Second instance: wrap-around reset PC, free-running memory, no stall.
  logic        zero_bit;
  logic [31:0] zero_word;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        id_valid2;
  logic [31:0] id_pc2;
  logic [31:0] id_instr2;

  int vectors;
  int miscompares;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  // Memory model: word = 0x100 + address, ack only against an active request.
  assign imem_ack    = ack_en & imem_req;
  assign imem_rdata  = 32'h100 + imem_addr;
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = 32'h100 + imem_addr2;
  assign zero_bit    = 1'b0;
  assign zero_word   = 32'h0;

  instr_fetch u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req2),
    .imem_addr   (imem_addr2),
    .imem_ack    (imem_ack2),
    .imem_rdata  (imem_rdata2),
    .stall       (zero_bit),
    .redirect    (zero_bit),
    .redirect_pc (zero_word),
    .id_valid    (id_valid2),
    .id_pc       (id_pc2),
    .id_instr    (id_instr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = 32'h100 + pc;
    exp_q.push_back(e);
  endtask

  // One cycle: inputs change just after the rising edge, checks follow at the
  // falling edge of the same cycle.
  task automatic cyc(input logic r, input logic s, input logic rd,
                     input logic [31:0] rpc, input logic ack);
    @(posedge clk);
    #1;
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    ack_en      = ack;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},   {31'b0, imem_req}, 32'h0);
    check({tag, "_addr"},  imem_addr,         32'h0);
    check({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
    check({tag, "_pc"},    id_pc,             32'h0);
    check({tag, "_instr"}, id_instr,          32'h0000_0013);
  endtask

  // Scoreboard monitor: every accepted IF/ID word must be the next expected one.
  always @(negedge clk) begin
    if (id_valid && !stall) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got pc %h instr %h expected none", id_pc, id_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("xfer pc %h instr %h (expect pc %h instr %h)", id_pc, id_instr, e.pc, e.instr);
        check("xfer_pc", id_pc, e.pc);
        check("xfer_instr", id_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ack_en      = 1'b0;

    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    check_reset_state("rst");

    // Test 1: streaming, then test 2 stalls into the skid buffer.
    for (int i = 0; i <= 8; i++) push_exp(32'(4 * i));

    cyc(0, 0, 0, 32'h0, 1);                           // c0 IDLE
    check("c0_req", {31'b0, imem_req}, 32'h0);
    check("c0_valid", {31'b0, id_valid}, 32'h0);
    cyc(0, 0, 0, 32'h0, 1);                           // c1
    check("c1_req", {31'b0, imem_req}, 32'h1);
    check("c1_addr", imem_addr, 32'h0);
    check("wrap_c1_addr", imem_addr2, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'h0, 1);                           // c2
    check("c2_addr", imem_addr, 32'h4);
    check("c2_id_pc", id_pc, 32'h0);
    check("wrap_c2_addr", imem_addr2, 32'h0);
    check("wrap_c2_id_pc", id_pc2, 32'hFFFF_FFFC);
    check("wrap_c2_id_instr", id_instr2, 32'h0000_00FC);
    cyc(0, 0, 0, 32'h0, 1);                           // c3
    check("wrap_c3_addr", imem_addr2, 32'h4);
    check("wrap_c3_id_pc", id_pc2, 32'h0);
    for (int i = 4; i <= 7; i++) cyc(0, 0, 0, 32'h0, 1);
    check("c7_addr", imem_addr, 32'h18);

    cyc(0, 1, 0, 32'h0, 1);                           // c8 word 28 -> buffer
    for (int i = 9; i <= 10; i++) begin
      cyc(0, 1, 0, 32'h0, 1);
      check("stall_req", {31'b0, imem_req}, 32'h0);
      check("stall_valid", {31'b0, id_valid}, 32'h1);
      check("stall_id_pc", id_pc, 32'h18);
      check("stall_id_instr", id_instr, 32'h118);
    end
    cyc(0, 0, 0, 32'h0, 1);                           // c11
    check("unstall_req", {31'b0, imem_req}, 32'h0);
    cyc(0, 0, 0, 32'h0, 1);                           // c12
    check("resume_req", {31'b0, imem_req}, 32'h1);
    check("resume_addr", imem_addr, 32'h20);
    check("buf_id_pc", id_pc, 32'h1C);

    // Test 3: redirect while the ack is late.
    cyc(0, 0, 0, 32'h0, 0);                           // c13
    push_exp(32'h100);
    cyc(0, 0, 1, 32'h103, 0);                         // c14
    cyc(0, 0, 0, 32'h0, 1);                           // c15 DROP, late ack
    check("drop_req", {31'b0, imem_req}, 32'h1);
    check("drop_addr", imem_addr, 32'h24);
    check("drop_valid", {31'b0, id_valid}, 32'h0);
    cyc(0, 0, 0, 32'h0, 1);                           // c16
    check("redir_addr", imem_addr, 32'h100);
    check("late_valid", {31'b0, id_valid}, 32'h0);
    cyc(0, 0, 0, 32'h0, 1);                           // c17

    // Test 4: redirect and stall together with a valid IF/ID.
    push_exp(32'h200);
    push_exp(32'h204);
    push_exp(32'h208);
    cyc(0, 1, 1, 32'h200, 1);                         // c18
    cyc(0, 0, 0, 32'h0, 1);                           // c19
    check("flush_valid", {31'b0, id_valid}, 32'h0);
    check("flush_instr", id_instr, 32'h0000_0013);
    check("flush_addr", imem_addr, 32'h200);
    cyc(0, 0, 0, 32'h0, 1);                           // c20
    cyc(0, 0, 0, 32'h0, 1);                           // c21
    cyc(0, 0, 0, 32'h0, 0);                           // c22

    // Test 6: reset while FULL.
    cyc(0, 1, 0, 32'h0, 1);                           // c23
    cyc(0, 1, 0, 32'h0, 1);                           // c24
    cyc(1, 1, 0, 32'h0, 0);                           // c25
    check("full_req", {31'b0, imem_req}, 32'h0);
    check("full_id_pc", id_pc, 32'h20C);
    cyc(0, 0, 0, 32'h0, 1);                           // c26
    check_reset_state("rst_full");
    push_exp(32'h0);
    cyc(0, 0, 0, 32'h0, 1);                           // c27
    check("restart_req", {31'b0, imem_req}, 32'h1);
    check("restart_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 32'h0, 0);                           // c28
    cyc(0, 0, 0, 32'h0, 0);                           // c29
    check("queue_left", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
